jtcus30_dcmix: RTL and testbench
================================

JTCUS30_DCMIX -- requirements
Module: jtcus30_dcmix

Interface
REQ-001 SHALL have parameter GSHIFT, default 2: right-shift applied to the gain product.
REQ-002 SHALL have port clk, input, 1 bit: system clock, the only clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cen, input, 1 bit: 1.5 MHz clock enable; it paces the processing steps.
REQ-005 SHALL have port in_stb, input, 1 bit: single-clk pulse marking a new snd_l/snd_r pair from the CUS30 mixer.
REQ-006 SHALL have ports snd_l and snd_r, input, 11 bits each: unsigned channel sums.
REQ-007 SHALL have port gain, input, 8 bits: unsigned 4.4 fixed-point gain, where 0x10 is unity.
REQ-008 SHALL have port mute, input, 1 bit: when high, the outputs are forced to zero.
REQ-009 SHALL have ports out_l and out_r, output, 16 bits each: signed, DC-removed, scaled samples.
REQ-010 SHALL have port out_stb, output, 1 bit: single-clk pulse on the clk where out_l/out_r update.
REQ-011 SHALL have port clip, output, 1 bit: valid with out_stb; high if either channel saturated.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag for a dropped input pair; cleared only by reset.

Function
REQ-013 SHALL capture snd_l/snd_r into holding registers on any clk where in_stb=1, independent of cen.
REQ-014 SHALL use FSM states IDLE, DCL, DCR, MULL, MULR, OUT.
- Transition IDLE->DCL occurs on the first cen at or after a pending capture.
- Each later state advances on one cen.
- OUT->IDLE occurs on cen.
REQ-015 SHALL assert out_stb, and update out_l/out_r/clip, on the clk where OUT exits on cen (latency 6 cen after capture, excluding wait for the first cen).
REQ-016 SHALL keep one DC accumulator per channel, acc 18-bit unsigned, with mean = acc[17:7].
- In DCx: centered = x - mean (12-bit signed, computed from the pre-update mean).
- In DCx: acc <= acc + x - mean.
REQ-017 SHALL share a single 12x9 signed multiplier (gain zero-extended) time-multiplexed across MULL then MULR.
- product = centered*gain.
- result = product >>> GSHIFT (arithmetic shift).
REQ-018 SHALL saturate each result to [-32768, 32767]; clip = OR of the saturation events of the two channels.
REQ-019 SHALL output 0 on out_l/out_r when mute=1 at OUT; clip SHALL then be 0; out_stb and the DC accumulators SHALL be unaffected.
REQ-020 SHALL, on in_stb while the FSM is not IDLE, hold the new pair as pending (one deep) and process it after the current OUT.
REQ-021 SHALL, on in_stb while a pair is already pending, overwrite the pending pair and set overrun.
REQ-022 SHALL resolve in_stb arriving on the same clk as the OUT exit by treating it as pending, with no overrun.
REQ-023 SHALL sample gain at MULL and use that value for both channels of the pair.
REQ-024 SHALL hold the accumulators constant during IDLE and on clks without cen.

Reset
REQ-025 SHALL, while rst_n=0, set:
- FSM to IDLE, pending clear;
- out_l/out_r = 0, out_stb = 0, clip = 0, overrun = 0;
- both acc = 0x400<<7 (midscale mean 0x400);
- holding registers = 0x400.
REQ-026 SHALL discard, on rst_n assertion mid-operation, any in-flight or pending pair without producing out_stb.

Structure
REQ-027 SHALL place the FSM state enum, the widths (11/12/16/18) and the midscale constant in package jtcus30_pkg.
REQ-028 SHALL implement the per-channel DC accumulator as sub-module jtcus30_dcblk, instantiated twice; the multiplier and saturation stay in the top.

Verification
REQ-029 SHALL test: reset, then in_stb with snd_l=snd_r=0x400, gain 0x10 -> out_l=out_r=0, clip=0, out_stb after 6 cen.
REQ-030 SHALL test: from reset, one pair snd_l=0x500, snd_r=0x300, gain 0x10 -> out_l=+1024, out_r=-1024; repeating the pair -> |out| strictly decreasing toward 0.
REQ-031 SHALL test: from reset, snd_l=0x7FF, snd_r=0x000, gain 0xFF -> out_l=32767, out_r=-32768, clip=1.
REQ-032 SHALL test: three in_stb pulses 2 clk apart while busy -> two out_stb pulses (first and third pairs), overrun=1.
REQ-033 SHALL test: mute=1 with snd_l=0x500 -> out_l=0, out_stb pulses; then mute=0 with the same input -> out_l equals the value after one unmuted accumulator update (1016).
REQ-034 SHALL test: rst_n low during MULL -> no out_stb, all outputs 0; the next pair processes normally.

Source files
------------

// File: rtl/jtcus30_pkg.sv
// jtcus30_pkg: shared widths, FSM states and saturation helper for the CUS30 DC mixer
package jtcus30_pkg;
  localparam int SND_W = 11;
  localparam int CTR_W = 12;
  localparam int OUT_W = 16;
  localparam int ACC_W = 18;
  localparam int PRD_W = 21;
  localparam logic [SND_W-1:0] MIDSCALE = 11'h400;
  localparam logic signed [PRD_W-1:0] SMAX = 21'sd32767;
  localparam logic signed [PRD_W-1:0] SMIN = -21'sd32768;
  typedef enum logic [2:0] {IDLE, DCL, DCR, MULL, MULR, OUT} state_t;
  function automatic logic [OUT_W:0] sat16(input logic signed [PRD_W-1:0] v);
    return v > SMAX ? {1'b1, 16'h7fff} : v < SMIN ? {1'b1, 16'h8000} : {1'b0, v[OUT_W-1:0]};
  endfunction
endpackage

// File: rtl/jtcus30_dcmix_if.sv
// jtcus30_dcmix_if: sample bus between the CUS30 mixer source and the DC mixer
interface jtcus30_dcmix_if;
  logic        in_stb;
  logic [10:0] snd_l, snd_r;
  logic [7:0]  gain;
  logic        mute;
  logic [15:0] out_l, out_r;
  logic        out_stb, clip, overrun;
  modport master(output in_stb, snd_l, snd_r, gain, mute, input out_l, out_r, out_stb, clip, overrun);
  modport slave(input in_stb, snd_l, snd_r, gain, mute, output out_l, out_r, out_stb, clip, overrun);
endinterface

// File: rtl/jtcus30_dcblk.sv
// jtcus30_dcblk: per-channel DC tracker, centered = x - acc[17:7], acc += centered
module jtcus30_dcblk import jtcus30_pkg::*; (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [SND_W-1:0]        x,
  output logic signed [CTR_W-1:0] centered
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic signed [CTR_W-1:0] ctr, ctr_q, ctr_d;
  always_comb begin
    ctr = $signed({1'b0, x}) - $signed({1'b0, acc_q[ACC_W-1:ACC_W-SND_W]});
    acc_d = en ? acc_q + {{(ACC_W-CTR_W){ctr[CTR_W-1]}}, ctr} : acc_q;
    ctr_d = en ? ctr : ctr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q <= {MIDSCALE, 7'd0};
      ctr_q <= '0;
    end else begin
      acc_q <= acc_d;
      ctr_q <= ctr_d;
    end
  assign centered = ctr_q;
endmodule

// File: rtl/jtcus30_dcmix.sv
// jtcus30_dcmix: DC removal, shared-multiplier gain and saturation for CUS30 stereo sums
module jtcus30_dcmix import jtcus30_pkg::*; #(parameter int GSHIFT = 2) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             in_stb,
  input  logic [SND_W-1:0] snd_l,
  input  logic [SND_W-1:0] snd_r,
  input  logic [7:0]       gain,
  input  logic             mute,
  output logic [OUT_W-1:0] out_l,
  output logic [OUT_W-1:0] out_r,
  output logic             out_stb,
  output logic             clip,
  output logic             overrun
);
  state_t state_q, state_d;
  logic pend_q, pend_d, ovr_q, ovr_d, stb_q, stb_d, clip_q, clip_d, start, fin;
  logic [SND_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d, cur_l_q, cur_l_d, cur_r_q, cur_r_d;
  logic [7:0] gain_q, gain_d, mul_b;
  logic [OUT_W:0] res_l_q, res_l_d, res_r_q, res_r_d, sat;
  logic [OUT_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic signed [CTR_W-1:0] ctr_l, ctr_r, mul_a;
  logic signed [PRD_W-1:0] prod;

  jtcus30_dcblk u_dcl (.clk(clk), .rst_n(rst_n), .en(cen && state_q == DCL), .x(cur_l_q), .centered(ctr_l));
  jtcus30_dcblk u_dcr (.clk(clk), .rst_n(rst_n), .en(cen && state_q == DCR), .x(cur_r_q), .centered(ctr_r));

  always_comb begin
    state_d = state_q;
    if (cen)
      case (state_q)
        IDLE:    state_d = pend_q ? DCL : IDLE;
        DCL:     state_d = DCR;
        DCR:     state_d = MULL;
        MULL:    state_d = MULR;
        MULR:    state_d = OUT;
        default: state_d = IDLE;
      endcase
  end

  always_comb begin
    start    = cen && state_q == IDLE && pend_q;
    fin      = cen && state_q == OUT;
    pend_d   = in_stb || (pend_q && !start);
    ovr_d    = ovr_q || (in_stb && pend_q && !start);
    hold_l_d = in_stb ? snd_l : hold_l_q;
    hold_r_d = in_stb ? snd_r : hold_r_q;
    cur_l_d  = start ? hold_l_q : cur_l_q;
    cur_r_d  = start ? hold_r_q : cur_r_q;
    mul_a    = state_q == MULL ? ctr_l : ctr_r;
    mul_b    = state_q == MULL ? gain : gain_q;
    prod     = PRD_W'(mul_a) * PRD_W'($signed({1'b0, mul_b}));
    sat      = sat16(prod >>> GSHIFT);
    gain_d   = cen && state_q == MULL ? gain : gain_q;
    res_l_d  = cen && state_q == MULL ? sat : res_l_q;
    res_r_d  = cen && state_q == MULR ? sat : res_r_q;
    stb_d    = fin;
    out_l_d  = fin ? (mute ? '0 : res_l_q[OUT_W-1:0]) : out_l_q;
    out_r_d  = fin ? (mute ? '0 : res_r_q[OUT_W-1:0]) : out_r_q;
    clip_d   = fin ? !mute && (res_l_q[OUT_W] || res_r_q[OUT_W]) : clip_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      stb_q    <= 1'b0;
      clip_q   <= 1'b0;
      hold_l_q <= MIDSCALE;
      hold_r_q <= MIDSCALE;
      cur_l_q  <= MIDSCALE;
      cur_r_q  <= MIDSCALE;
      gain_q   <= '0;
      res_l_q  <= '0;
      res_r_q  <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      stb_q    <= stb_d;
      clip_q   <= clip_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      cur_l_q  <= cur_l_d;
      cur_r_q  <= cur_r_d;
      gain_q   <= gain_d;
      res_l_q  <= res_l_d;
      res_r_q  <= res_r_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
    end

  assign out_l   = out_l_q;
  assign out_r   = out_r_q;
  assign out_stb = stb_q;
  assign clip    = clip_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_jtcus30_dcmix.sv
// tb_jtcus30_dcmix: directed scoreboard bench for the CUS30 DC mixer
module tb_jtcus30_dcmix;
  localparam int GSHIFT = 2;
  typedef struct {int l; int r; int c;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0;
  logic [1:0] ph = 2'd0;
  int checks = 0, failures = 0, stb_cnt = 0;
  int acc_l, acc_r;
  exp_t sb[$];
  logic signed [15:0] last_l = '0, last_r = '0;
  logic last_clip = 1'b0;

  jtcus30_dcmix_if bus();

  jtcus30_dcmix #(.GSHIFT(GSHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .in_stb(bus.in_stb),
    .snd_l(bus.snd_l), .snd_r(bus.snd_r), .gain(bus.gain), .mute(bus.mute),
    .out_l(bus.out_l), .out_r(bus.out_r), .out_stb(bus.out_stb),
    .clip(bus.clip), .overrun(bus.overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ph = ph + 2'd1;
    cen = (ph == 2'd3);
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  task automatic push_exp(input int l, input int r, input int g, input bit m);
    int cl, cr, pl, pr;
    exp_t e;
    cl = l - (acc_l >>> 7);
    acc_l += cl;
    cr = r - (acc_r >>> 7);
    acc_r += cr;
    pl = (cl * g) >>> GSHIFT;
    pr = (cr * g) >>> GSHIFT;
    e.l = m ? 0 : sat(pl);
    e.r = m ? 0 : sat(pr);
    e.c = (!m && (sat(pl) != pl || sat(pr) != pr)) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic pulse(input int l, input int r);
    bus.in_stb = 1'b1;
    bus.snd_l = 11'(l);
    bus.snd_r = 11'(r);
    @(posedge clk);
    #1 bus.in_stb = 1'b0;
  endtask

  task automatic send(input int l, input int r);
    do begin
      @(posedge clk);
      #1;
    end while (ph != 2'd1);
    pulse(l, r);
  endtask

  task automatic run_pair(input int l, input int r, input int g, input bit m);
    int n, t;
    bus.gain = 8'(g);
    bus.mute = m;
    push_exp(l, r, g, m);
    send(l, r);
    n = 0;
    t = 0;
    while (bus.out_stb !== 1'b1 && t < 200) begin
      @(posedge clk);
      if (cen) n++;
      #1 t++;
    end
    chk("latency_cen", n, 6);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    sb.delete();
    acc_l = 'h400 << 7;
    acc_r = 'h400 << 7;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk)
    if (bus.out_stb === 1'b1) begin
      exp_t e;
      stb_cnt++;
      last_l = $signed(bus.out_l);
      last_r = $signed(bus.out_r);
      last_clip = bus.clip;
      if (sb.size() == 0) chk("unexpected_stb", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("sb_out_l", last_l, e.l);
        chk("sb_out_r", last_r, e.r);
        chk("sb_clip", last_clip, e.c);
      end
    end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int base, prev, a, t;
    bus.in_stb = 1'b0;
    bus.snd_l = '0;
    bus.snd_r = '0;
    bus.gain = 8'h10;
    bus.mute = 1'b0;
    do_reset;
    chk("rst_out_l", $signed(bus.out_l), 0);
    chk("rst_out_r", $signed(bus.out_r), 0);
    chk("rst_out_stb", bus.out_stb, 0);
    chk("rst_clip", bus.clip, 0);
    chk("rst_overrun", bus.overrun, 0);

    run_pair('h400, 'h400, 'h10, 1'b0);
    chk("mid_l", last_l, 0);
    chk("mid_r", last_r, 0);
    chk("mid_clip", last_clip, 0);

    do_reset;
    run_pair('h500, 'h300, 'h10, 1'b0);
    chk("step_l", last_l, 1024);
    chk("step_r", last_r, -1024);
    prev = 1024;
    for (int i = 0; i < 3; i++) begin
      run_pair('h500, 'h300, 'h10, 1'b0);
      a = last_l < 0 ? -int'(last_l) : int'(last_l);
      chk("decay_l", int'(a < prev && a > 0), 1);
      prev = a;
    end

    do_reset;
    run_pair('h7ff, 'h000, 'hff, 1'b0);
    chk("sat_l", last_l, 32767);
    chk("sat_r", last_r, -32768);
    chk("sat_clip", last_clip, 1);

    do_reset;
    run_pair('h500, 'h300, 'h10, 1'b1);
    chk("mute_l", last_l, 0);
    chk("mute_clip", last_clip, 0);
    run_pair('h500, 'h300, 'h10, 1'b0);
    chk("unmute_l", last_l, 1016);
    chk("no_overrun_yet", bus.overrun, 0);

    do_reset;
    bus.gain = 8'h10;
    bus.mute = 1'b0;
    base = stb_cnt;
    push_exp('h500, 'h300, 'h10, 1'b0);
    send('h500, 'h300);
    @(posedge clk);
    #1 pulse('h100, 'h100);
    @(posedge clk);
    #1 pulse('h600, 'h200);
    push_exp('h600, 'h200, 'h10, 1'b0);
    t = 0;
    while (stb_cnt < base + 2 && t < 400) begin
      @(posedge clk);
      #1 t++;
    end
    repeat (60) @(posedge clk);
    #1;
    chk("ovr_stb_count", stb_cnt - base, 2);
    chk("ovr_flag", bus.overrun, 1);
    chk("ovr_third_l", last_l, 2040);
    chk("ovr_third_r", last_r, -2040);
    chk("ovr_sb_empty", sb.size(), 0);

    do_reset;
    base = stb_cnt;
    send('h500, 'h300);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("kill_no_stb", stb_cnt - base, 0);
    chk("kill_out_l", $signed(bus.out_l), 0);
    chk("kill_out_r", $signed(bus.out_r), 0);
    chk("kill_clip", bus.clip, 0);
    chk("kill_overrun", bus.overrun, 0);
    run_pair('h500, 'h300, 'h10, 1'b0);
    chk("after_kill_l", last_l, 1024);
    chk("after_kill_r", last_r, -1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
